pmac_accumulator: RTL and testbench
===================================

# pmac_accumulator

Parametrised successor to the convolution MAC: N-lane signed multiply, pipelined adder tree and group accumulator in one block. Adds multi-beat accumulation for kernels wider than the lane count, selectable saturate/wrap arithmetic, a sticky per-result overflow flag, and valid/ready backpressure. Sits between the IF-map/kernel-weight buffers and the output-feature-map writer.

## Interface

Clock and reset: one clock; reset is synchronous and active-low.

Parameters:
- `LANES`, default 64: multiplier lanes; power of two, 2..256.
- `DW`, default 16: signed operand width per lane.
- `ACCW`, default 32: accumulator and result width; must be at least `2*DW`.
- `SATURATE`, default 1: 1 clamps on overflow; 0 wraps (two's-complement truncation).

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-low.
- `clear`, in, 1: synchronous flush of the pipeline and accumulator.
- `in_valid`, in, 1: beat present.
- `in_ready`, out, 1: beat accepted when `in_valid && in_ready`.
- `in_last`, in, 1: beat closes the current accumulation group.
- `lane_en`, in, `LANES`: per-lane enable; a disabled lane contributes 0.
- `if_data`, in, `LANES*DW`: IF-map operands; lane i is at `[i*DW +: DW]`.
- `kw_data`, in, `LANES*DW`: kernel-weight operands, packed the same way.
- `out_valid`, out, 1: result held.
- `out_ready`, in, 1: result consumed when `out_valid && out_ready`.
- `out_data`, out, `ACCW`: signed group result.
- `out_ovf`, out, 1: sticky overflow for this group.

## Operation

- **Stage M (1 cycle).** Registers product_i = `if_i * kw_i` (signed, `2*DW` bits), or 0 when `lane_en[i]=0`. A product cannot overflow.
- **Stage T (`log2(LANES)` cycles).** Pipelined binary adder tree. Each level widens by 1 bit, so the tree is exact. The sum width is SW = `2*DW + log2(LANES)` (38 at the defaults).
- **Stage A (1 cycle).**
  - Computes acc_base + sum at full precision, where acc_base is 0 on the first beat of a group and acc otherwise.
  - A first beat is the first beat after reset, `clear`, or a beat with `in_last` set.
  - If the result is not representable in `ACCW` signed bits, `ovf_grp` is set; it stays set until the group closes.
  - `SATURATE=1`: acc is clamped to `2^(ACCW-1)-1` or `-2^(ACCW-1)`, and later beats add to the clamped value.
  - `SATURATE=0`: acc takes the low `ACCW` bits.
- **Group close.** On an `in_last` beat at stage A, {acc result, ovf_grp} loads the output register and `out_valid` is set. The accumulator is then free, so the next group may enter stage A on the following cycle.
- **Stall.**
  - stall = `out_valid && !out_ready`.
  - `in_ready = !stall`.
  - During a stall all pipeline registers, valid bits, acc and ovf_grp hold. No beat is lost or duplicated.
- **`out_valid` clear.** Cleared on a handshake unless a new result loads in the same cycle; load wins.
- **`clear`.**
  - Kills all in-flight valid bits, zeroes acc and ovf_grp, and makes the next beat a first beat.
  - A held output result is unaffected.
  - `clear` together with `in_valid`: `clear` wins, the beat is dropped and `in_ready` reads 0 that cycle.
- **`reset` low.**
  - All valid bits, acc, ovf_grp, `out_valid`, `out_data` and `out_ovf` go to 0, mid-operation included.
  - The first-beat flag is set.
  - `in_ready` is 0 while `reset` is low.

## Timing

- Latency from beat acceptance to `out_valid` is L = `log2(LANES) + 2` cycles with no stall (8 at the defaults).
- Throughput is 1 beat per cycle with `out_ready` held high.
- Outputs are registered except `in_ready`, which is combinational from `out_valid`, `out_ready`, `clear` and `reset`.
- An N-beat group produces its result L cycles after its last beat is accepted.

## Structure

- Shared package `pmac_pkg`:
  - clog2 function;
  - SW derivation function;
  - ACCW max/min constant functions for the saturation bounds;
  - lane-slice helper.
- Sub-module `pmac_adder_tree`:
  - parametrised `LANES` and input width;
  - registered per level, with valid propagation and a common enable.
  - Everything else lives in the top module.

## Test plan

All scenarios use the defaults unless stated.

- **Single beat, all lanes.** All lanes `if=1`, `kw=2`, `lane_en` all 1, `in_last=1` → `out_data=128`, `out_ovf=0`, `out_valid` exactly 8 cycles after acceptance.
- **Masking and sign.** Only lane 0 enabled, `if=-3`, `kw=5`, other lanes `0x7FFF` → `out_data=-15` (`0xFFFFFFF1`).
- **Overflow.** All lanes `0x7FFF*0x7FFF`, single last beat:
  - `SATURATE=1` → `0x7FFFFFFF`, `out_ovf=1`;
  - `SATURATE=0` → `0xFFC00040`, `out_ovf=1`;
  - the next group of scenario 1 → 128, `out_ovf=0`.
- **Back-to-back groups.** Group A = 2 beats of the scenario 1 data, group B = 1 beat issued the next cycle → results 256 then 128, in order, with no carry-over.
- **Backpressure.** A 12-beat stream of single-beat groups with `out_ready` low for 5 cycles → `in_ready` drops, all 12 results arrive in order, and a scoreboard shows no loss or duplication.
- **`clear` and `reset` mid-operation.**
  - `clear` after beat 1 of a 3-beat group, then a fresh 1-beat group → that group's value only.
  - `reset` low with 4 beats in flight → all outputs are 0 next cycle and no stale `out_valid` appears after release.

Source files
------------

// File: rtl/pmac_pkg.sv
// Shared constants and helpers for the pmac_accumulator datapath.
package pmac_pkg;

  localparam int unsigned BoundW = 128;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Exact adder-tree output width: full product plus one bit per tree level.
  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned lanes);
    return 2 * dw + clog2(lanes);
  endfunction

  function automatic logic [BoundW-1:0] acc_max(input int unsigned accw);
    return (BoundW'(1) << (accw - 1)) - BoundW'(1);
  endfunction

  // Sign-extended to BoundW so callers can truncate to any wider compare width.
  function automatic logic [BoundW-1:0] acc_min(input int unsigned accw);
    return ~acc_max(accw);
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/pmac_adder_tree.sv
// Pipelined signed binary adder tree, one register level per halving, common stall enable.
module pmac_adder_tree
  import pmac_pkg::*;
#(
  parameter int unsigned LANES = 64,
  parameter int unsigned IW    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          en_i,
  input  logic                          in_valid_i,
  input  logic [LANES*IW-1:0]           in_data_i,
  output logic                          out_valid_o,
  output logic [IW+clog2(LANES)-1:0]    out_data_o
);

  localparam int unsigned Levels = clog2(LANES);

  for (genvar l = 0; l < Levels; l++) begin : g_lvl
    localparam int unsigned Nodes = LANES >> (l + 1);
    localparam int unsigned InW   = IW + l;
    localparam int unsigned OutW  = InW + 1;

    logic [2*Nodes*InW-1:0] in_vec;
    logic                   in_vld;
    logic [Nodes*OutW-1:0]  sum_d, sum_q;
    logic                   vld_q;

    if (l == 0) begin : g_head
      assign in_vec = in_data_i;
      assign in_vld = in_valid_i;
    end else begin : g_body
      assign in_vec = g_lvl[l-1].sum_q;
      assign in_vld = g_lvl[l-1].vld_q;
    end

    always_comb begin
      sum_d = '0;
      for (int unsigned n = 0; n < Nodes; n++) begin
        sum_d[n*OutW +: OutW] = OutW'($signed(in_vec[2*n*InW +: InW]))
                              + OutW'($signed(in_vec[(2*n+1)*InW +: InW]));
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
        vld_q <= 1'b0;
      end else if (en_i) begin
        vld_q <= in_vld;
      end
    end

    // Data needs no reset: it is only observed alongside vld_q.
    always_ff @(posedge clk_i) begin
      if (en_i) begin
        sum_q <= sum_d;
      end
    end
  end

  assign out_data_o  = g_lvl[Levels-1].sum_q;
  assign out_valid_o = g_lvl[Levels-1].vld_q;

endmodule

// File: rtl/pmac_accumulator.sv
// N-lane signed MAC: product stage, pipelined adder tree, group accumulator with
// saturate/wrap, sticky overflow and valid/ready backpressure.
module pmac_accumulator
  import pmac_pkg::*;
#(
  parameter int unsigned LANES    = 64,
  parameter int unsigned DW       = 16,
  parameter int unsigned ACCW     = 32,
  parameter int unsigned SATURATE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES-1:0]      lane_en,
  input  logic [LANES*DW-1:0]   if_data,
  input  logic [LANES*DW-1:0]   kw_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCW-1:0]       out_data,
  output logic                  out_ovf
);

  localparam int unsigned Levels = clog2(LANES);
  localparam int unsigned PW     = 2 * DW;
  localparam int unsigned SW     = sum_width(DW, LANES);
  localparam int unsigned ExtW   = ((SW > ACCW) ? SW : ACCW) + 1;
  localparam logic [ExtW-1:0] AccMaxExt = ExtW'(acc_max(ACCW));
  localparam logic [ExtW-1:0] AccMinExt = ExtW'(acc_min(ACCW));

  logic stall, adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = reset && !clear && !stall;

  // Stage M: per-lane products
  logic [LANES*PW-1:0] prod_d, prod_q;
  logic                m_vld_q, m_last_q;

  always_comb begin
    prod_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        prod_d[lane_lsb(i, PW) +: PW] = PW'($signed(if_data[lane_lsb(i, DW) +: DW]))
                                      * PW'($signed(kw_data[lane_lsb(i, DW) +: DW]));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      m_vld_q <= 1'b0;
    end else if (adv) begin
      m_vld_q <= in_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (adv) begin
      prod_q   <= prod_d;
      m_last_q <= in_last;
    end
  end

  // Stage T: adder tree, with the last flag travelling alongside
  logic          t_vld;
  logic [SW-1:0] t_sum;
  logic [Levels-1:0] t_last_q;

  pmac_adder_tree #(
    .LANES (LANES),
    .IW    (PW)
  ) u_tree (
    .clk_i       (clock),
    .rst_ni      (reset),
    .flush_i     (clear),
    .en_i        (adv),
    .in_valid_i  (m_vld_q),
    .in_data_i   (prod_q),
    .out_valid_o (t_vld),
    .out_data_o  (t_sum)
  );

  always_ff @(posedge clock) begin
    if (adv) begin
      t_last_q[0] <= m_last_q;
      for (int unsigned i = 1; i < Levels; i++) begin
        t_last_q[i] <= t_last_q[i-1];
      end
    end
  end

  // Stage A: accumulate at full precision, then clamp or wrap
  logic [ACCW-1:0] acc_d, acc_q, res;
  logic            ovf_grp_d, ovf_grp_q, first_d, first_q;
  logic            out_valid_d, out_valid_q, out_ovf_d, out_ovf_q;
  logic [ACCW-1:0] out_data_d, out_data_q;
  logic [ExtW-1:0] sum_ext, base_ext, full;
  logic            over_hi, over_lo, ovf_new, a_fire, t_last, load;

  assign t_last = t_last_q[Levels-1];
  assign a_fire = t_vld && adv && !clear;
  assign load   = a_fire && t_last;

  always_comb begin
    sum_ext  = ExtW'($signed(t_sum));
    base_ext = first_q ? '0 : ExtW'($signed(acc_q));
    full     = sum_ext + base_ext;
    over_hi  = $signed(full) > $signed(AccMaxExt);
    over_lo  = $signed(full) < $signed(AccMinExt);
    ovf_new  = over_hi || over_lo || (!first_q && ovf_grp_q);
    res      = full[ACCW-1:0];
    if (SATURATE != 0) begin
      if (over_hi) res = AccMaxExt[ACCW-1:0];
      if (over_lo) res = AccMinExt[ACCW-1:0];
    end
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_grp_d   = ovf_grp_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (clear) begin
      acc_d     = '0;
      ovf_grp_d = 1'b0;
      first_d   = 1'b1;
    end else if (a_fire) begin
      acc_d     = res;
      ovf_grp_d = ovf_new;
      first_d   = t_last;
    end
    // A new result wins over a same-cycle handshake.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_ovf_d   = ovf_new;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q       <= '0;
      ovf_grp_q   <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_grp_q   <= ovf_grp_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pmac_accumulator.sv
// Directed bench for pmac_accumulator: a saturating and a wrapping instance share stimulus.
module tb_pmac_accumulator;

  localparam int unsigned Lanes = 64;
  localparam int unsigned Dw    = 16;
  localparam int unsigned Accw  = 32;

  logic clock = 1'b0;
  logic reset, clear, in_valid, in_last, out_ready;
  logic [Lanes-1:0]    lane_en;
  logic [Lanes*Dw-1:0] if_data, kw_data;
  logic in_ready0, out_valid0, out_ovf0;
  logic in_ready1, out_valid1, out_ovf1;
  logic [Accw-1:0] out_data0, out_data1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pmac_accumulator #(.LANES(Lanes), .DW(Dw), .ACCW(Accw), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
    .in_last(in_last), .lane_en(lane_en), .if_data(if_data), .kw_data(kw_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ovf(out_ovf0)
  );

  pmac_accumulator #(.LANES(Lanes), .DW(Dw), .ACCW(Accw), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .lane_en(lane_en), .if_data(if_data), .kw_data(kw_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ovf(out_ovf1)
  );

  task automatic set_lanes(input logic [15:0] a, input logic [15:0] b, input logic [63:0] en);
    for (int i = 0; i < 64; i++) begin
      if_data[i*16 +: 16] = a;
      kw_data[i*16 +: 16] = b;
    end
    lane_en = en;
  endtask

  // Present one beat at the next negedge; it is accepted at the following posedge.
  task automatic send_beat(input logic last);
    @(negedge clock);
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] d0, output logic o0,
                             output logic [31:0] d1, output logic o1, output bit ok);
    ok = 1'b0;
    d0 = '0; o0 = 1'b0; d1 = '0; o1 = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clock);
      #1;
      if (out_valid0) begin
        ok = 1'b1;
        d0 = out_data0; o0 = out_ovf0;
        d1 = out_data1; o1 = out_ovf1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    set_lanes(16'd0, 16'd0, 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
    n_vec++; if (out_data0 !== 32'd0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data0); end
    n_vec++; if (out_ovf0 !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf got %b want 0", out_ovf0); end
    n_vec++; if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready got %b%b want 00", in_ready0, in_ready1);
    end
    reset = 1'b1;
    #1;
    n_vec++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %b want 1", in_ready0); end
  endtask

  task automatic test_single_beat();
    int lat;
    set_lanes(16'd1, 16'd2, '1);
    @(negedge clock);
    in_valid = 1'b1; in_last = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    lat = out_valid0 ? 1 : 0;
    for (int n = 2; n <= 20 && lat == 0; n++) begin
      @(posedge clock);
      #1;
      if (out_valid0) lat = n;
    end
    n_vec++; if (lat != 8) begin n_err++; $display("FAIL single_latency got %0d want 8", lat); end
    n_vec++; if (out_data0 !== 32'd128) begin n_err++; $display("FAIL single_data got %0d want 128", out_data0); end
    n_vec++; if (out_ovf0 !== 1'b0) begin n_err++; $display("FAIL single_ovf got %b want 0", out_ovf0); end
    n_vec++; if (out_data1 !== 32'd128) begin n_err++; $display("FAIL single_data_wrap got %0d want 128", out_data1); end
  endtask

  task automatic test_mask_sign();
    logic [31:0] d0, d1; logic o0, o1; bit ok;
    set_lanes(16'h7FFF, 16'h7FFF, 64'h1);
    if_data[15:0] = 16'hFFFD;
    kw_data[15:0] = 16'd5;
    send_beat(1'b1);
    wait_result(d0, o0, d1, o1, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mask_timeout got none want result"); end
    n_vec++; if (d0 !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mask_data got %h want fffffff1", d0); end
    n_vec++; if (o0 !== 1'b0) begin n_err++; $display("FAIL mask_ovf got %b want 0", o0); end
  endtask

  task automatic test_overflow();
    logic [31:0] d0, d1; logic o0, o1; bit ok;
    set_lanes(16'h7FFF, 16'h7FFF, '1);
    send_beat(1'b1);
    wait_result(d0, o0, d1, o1, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_timeout got none want result"); end
    n_vec++; if (d0 !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL ovf_sat_data got %h want 7fffffff", d0); end
    n_vec++; if (o0 !== 1'b1) begin n_err++; $display("FAIL ovf_sat_flag got %b want 1", o0); end
    n_vec++; if (d1 !== 32'hFFC0_0040) begin n_err++; $display("FAIL ovf_wrap_data got %h want ffc00040", d1); end
    n_vec++; if (o1 !== 1'b1) begin n_err++; $display("FAIL ovf_wrap_flag got %b want 1", o1); end
    set_lanes(16'd1, 16'd2, '1);
    send_beat(1'b1);
    wait_result(d0, o0, d1, o1, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL post_ovf_timeout got none want result"); end
    n_vec++; if (d0 !== 32'd128 || d1 !== 32'd128) begin
      n_err++; $display("FAIL post_ovf_data got %0d/%0d want 128/128", d0, d1);
    end
    n_vec++; if (o0 !== 1'b0 || o1 !== 1'b0) begin
      n_err++; $display("FAIL post_ovf_flag got %b/%b want 0/0", o0, o1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1; logic o0, o1; bit ok;
    set_lanes(16'd1, 16'd2, '1);
    @(negedge clock);
    in_valid = 1'b1; in_last = 1'b0;
    @(posedge clock); #1 in_last = 1'b1;
    @(posedge clock); #1 in_last = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0; in_last = 1'b0;
    wait_result(d0, o0, d1, o1, ok);
    n_vec++; if (!ok || d0 !== 32'd256) begin n_err++; $display("FAIL b2b_first got %0d ok=%0d want 256", d0, ok); end
    wait_result(d0, o0, d1, o1, ok);
    n_vec++; if (!ok || d0 !== 32'd128) begin n_err++; $display("FAIL b2b_second got %0d ok=%0d want 128", d0, ok); end
    n_vec++; if (o0 !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %b want 0", o0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int sent = 0;
    bit saw_stall = 1'b0;
    set_lanes(16'd0, 16'd3, 64'h1);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clock);
      out_ready = !(cyc >= 10 && cyc < 15);
      #1;
      if (out_valid0 && out_ready) got.push_back(out_data0);
      if (!in_ready0) saw_stall = 1'b1;
      if (sent < 12) begin
        in_valid = 1'b1;
        in_last  = 1'b1;
        if_data[15:0] = 16'(sent + 1);
        if (in_ready0) sent++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    out_ready = 1'b1;
    n_vec++; if (!saw_stall) begin n_err++; $display("FAIL bp_in_ready_drop got 0 want 1"); end
    n_vec++; if (got.size() != 12) begin n_err++; $display("FAIL bp_count got %0d want 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      logic [31:0] act;
      act = (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
      n_vec++;
      if (act !== 32'(3 * (i + 1))) begin
        n_err++; $display("FAIL bp_result_%0d got %0d want %0d", i, act, 3 * (i + 1));
      end
    end
  endtask

  task automatic test_clear();
    logic [31:0] d0, d1; logic o0, o1; bit ok;
    int extra = 0;
    set_lanes(16'd1, 16'd2, '1);
    @(negedge clock);
    in_valid = 1'b1; in_last = 1'b0;
    @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    n_vec++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL clear_in_ready got %b want 0", in_ready0); end
    @(posedge clock);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    set_lanes(16'd0, 16'd0, 64'h1);
    if_data[15:0] = 16'd7;
    kw_data[15:0] = 16'd1;
    send_beat(1'b1);
    wait_result(d0, o0, d1, o1, ok);
    n_vec++; if (!ok || d0 !== 32'd7) begin n_err++; $display("FAIL clear_fresh got %0d ok=%0d want 7", d0, ok); end
    for (int n = 0; n < 15; n++) begin
      @(negedge clock);
      if (out_valid0) extra++;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL clear_stale got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    set_lanes(16'd1, 16'd2, '1);
    @(negedge clock);
    in_valid = 1'b1; in_last = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_in_ready got %b want 0", in_ready0); end
    @(posedge clock);
    #1;
    n_vec++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", out_valid0); end
    n_vec++; if (out_data0 !== 32'd0 || out_data1 !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_data got %h/%h want 0/0", out_data0, out_data1);
    end
    n_vec++; if (out_ovf0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_ovf got %b want 0", out_ovf0); end
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (out_valid0 || out_valid1) stale++;
    end
    n_vec++; if (stale != 0) begin n_err++; $display("FAIL rst_mid_stale got %0d want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_mask_sign();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
